alu: RTL and testbench

// - 32-bit integer ALU for the RV32I execute stage.
// - Operation is selected directly by the instruction funct3/funct7 fields.
// - Result and N/Z flags are combinational, with zero latency, for branch and writeback use.
// - Registered copies of the result and flags are also provided for pipelined consumers.

---
 rtl/alu_if.sv | 26 ++
 rtl/alu.sv | 53 +++++
 tb/tb_alu.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// Operand/result bundle between the RV32I execute stage and its ALU.
// The ALU sits on the slave side; the stage that supplies operands is the master.
interface alu_if;
    localparam int unsigned XLEN = 32;

    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] result;
    logic            negative;
    logic            zero;
    logic [XLEN-1:0] result_q;
    logic            negative_q;
    logic            zero_q;

    modport master (
        output in1, in2, funct3, funct7,
        input  result, negative, zero, result_q, negative_q, zero_q
    );

    modport slave (
        input  in1, in2, funct3, funct7,
        output result, negative, zero, result_q, negative_q, zero_q
    );
endinterface

// File: rtl/alu.sv
// 32-bit RV32I integer ALU: zero-latency result and N/Z flags,
// plus a one-cycle registered copy for pipelined consumers.
module alu (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);
    localparam int unsigned XLEN    = 32;
    localparam int unsigned SHAMT_W = 5;

    logic [XLEN-1:0]    res;
    logic [SHAMT_W-1:0] shamt;
    logic               alt;
    logic               unused_funct7;

    assign shamt         = bus.in2[SHAMT_W-1:0];
    assign alt           = bus.funct7[5];
    assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};

    // Operation decode straight from funct3, with funct7[5] picking SUB/SRA.
    always_comb begin
        res = '0;
        case (bus.funct3)
            3'b000:  res = alt ? (bus.in1 - bus.in2) : (bus.in1 + bus.in2);
            3'b001:  res = bus.in1 << shamt;
            3'b010:  res = XLEN'($signed(bus.in1) < $signed(bus.in2));
            3'b011:  res = XLEN'(bus.in1 < bus.in2);
            3'b100:  res = bus.in1 ^ bus.in2;
            3'b101:  res = alt ? XLEN'($unsigned($signed(bus.in1) >>> shamt))
                               : (bus.in1 >> shamt);
            3'b110:  res = bus.in1 | bus.in2;
            3'b111:  res = bus.in1 & bus.in2;
            default: res = '0;
        endcase
    end

    assign bus.result   = res;
    assign bus.negative = res[XLEN-1];
    assign bus.zero     = (res == '0);

    // Registered copies; reset forces all three to zero, including zero_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.result_q   <= '0;
            bus.negative_q <= 1'b0;
            bus.zero_q     <= 1'b0;
        end else begin
            bus.result_q   <= res;
            bus.negative_q <= res[XLEN-1];
            bus.zero_q     <= (res == '0);
        end
    end
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors from the operation table,
// then randomized operations checked against an arithmetic reference model.
module tb_alu;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    alu_if bus ();

    alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: operations expressed as plain 64-bit arithmetic on values.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f3, input logic [6:0] f7);
        longint ua, ub, sa, sb, p, r;
        int     sh;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        p  = longint'(2) ** sh;
        r  = 0;
        case (f3)
            3'd0: r = f7[5] ? (ua - ub) : (ua + ub);
            3'd1: r = ua * p;
            3'd2: r = (sa < sb) ? 1 : 0;
            3'd3: r = (ua < ub) ? 1 : 0;
            3'd4: r = longint'({32'd0, a ^ b});
            3'd5: begin
                if (!f7[5])     r = ua / p;
                else if (sa >= 0) r = sa / p;
                else            r = (sa - (p - 1)) / p;
            end
            3'd6: r = longint'({32'd0, a | b});
            default: r = longint'({32'd0, a & b});
        endcase
        return 32'(r);
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input logic [6:0] f7, input logic r);
        @(negedge clk);
        bus.in1    = a;
        bus.in2    = b;
        bus.funct3 = f3;
        bus.funct7 = f7;
        rst        = r;
        #1;
    endtask

    typedef struct {
        string       tag;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] exp;
        logic        n;
        logic        z;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] a, b, exp_r, r_exp_q;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        do_rst, n_exp_q, z_exp_q;

        n_checks = 0;
        n_fail   = 0;

        vecs.push_back('{"add_basic", 32'h0000000F, 32'h000000F0, 3'd0, 7'h00, 32'h000000FF, 1'b0, 1'b0});
        vecs.push_back('{"add_wrap",  32'hFFFFFFFF, 32'h00000001, 3'd0, 7'h00, 32'h00000000, 1'b0, 1'b1});
        vecs.push_back('{"sub_neg",   32'h00000000, 32'h00000001, 3'd0, 7'h20, 32'hFFFFFFFF, 1'b1, 1'b0});
        vecs.push_back('{"and",       32'hFF00FF00, 32'h0F0F0F0F, 3'd7, 7'h00, 32'h0F000F00, 1'b0, 1'b0});
        vecs.push_back('{"or",        32'hFF00FF00, 32'h0F0F0F0F, 3'd6, 7'h00, 32'hFF0FFF0F, 1'b1, 1'b0});
        vecs.push_back('{"xor",       32'h0000000C, 32'h0000000A, 3'd4, 7'h00, 32'h00000006, 1'b0, 1'b0});
        vecs.push_back('{"xor_f7",    32'h0000000C, 32'h0000000A, 3'd4, 7'h7F, 32'h00000006, 1'b0, 1'b0});
        vecs.push_back('{"sll",       32'h0000000F, 32'h00000004, 3'd1, 7'h00, 32'h000000F0, 1'b0, 1'b0});
        vecs.push_back('{"srl",       32'h000000F0, 32'h00000004, 3'd5, 7'h00, 32'h0000000F, 1'b0, 1'b0});
        vecs.push_back('{"sra_pos",   32'h00000010, 32'h00000002, 3'd5, 7'h20, 32'h00000004, 1'b0, 1'b0});
        vecs.push_back('{"sra_neg",   32'hFFFFFFFF, 32'h00000001, 3'd5, 7'h20, 32'hFFFFFFFF, 1'b1, 1'b0});
        vecs.push_back('{"srl_31",    32'h80000000, 32'h0000001F, 3'd5, 7'h00, 32'h00000001, 1'b0, 1'b0});
        vecs.push_back('{"sra_31",    32'h80000000, 32'h0000001F, 3'd5, 7'h20, 32'hFFFFFFFF, 1'b1, 1'b0});
        vecs.push_back('{"sll_zero",  32'h12345678, 32'hFFFFFFE0, 3'd1, 7'h00, 32'h12345678, 1'b0, 1'b0});
        vecs.push_back('{"slt",       32'hFFFFFFFF, 32'h00000001, 3'd2, 7'h00, 32'h00000001, 1'b0, 1'b0});
        vecs.push_back('{"sltu",      32'hFFFFFFFF, 32'h00000001, 3'd3, 7'h00, 32'h00000000, 1'b0, 1'b1});
        vecs.push_back('{"slt_f7",    32'hFFFFFFFF, 32'h00000001, 3'd2, 7'h20, 32'h00000001, 1'b0, 1'b0});

        // Reset state of the registered path.
        drive(32'h00000005, 32'h00000007, 3'd0, 7'h00, 1'b1);
        @(posedge clk); #1;
        check("rst_result_q", bus.result_q, 32'h0);
        check("rst_negative_q", 32'(bus.negative_q), 32'h0);
        check("rst_zero_q", 32'(bus.zero_q), 32'h0);
        check("rst_comb_live", bus.result, 32'h0000000C);

        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].f3, vecs[i].f7, 1'b0);
            check({vecs[i].tag, "_res"}, bus.result, vecs[i].exp);
            check({vecs[i].tag, "_n"}, 32'(bus.negative), 32'(vecs[i].n));
            check({vecs[i].tag, "_z"}, 32'(bus.zero), 32'(vecs[i].z));
            check({vecs[i].tag, "_model"}, ref_alu(vecs[i].a, vecs[i].b, vecs[i].f3, vecs[i].f7),
                  vecs[i].exp);
        end

        // Registered path: ADD 1+2 appears one edge later.
        drive(32'd1, 32'd2, 3'd0, 7'h00, 1'b0);
        @(posedge clk); #1;
        check("reg_add_q", bus.result_q, 32'd3);
        check("reg_add_zq", 32'(bus.zero_q), 32'd0);

        // Reset priority over a nonzero and over a zero result.
        drive(32'hFFFFFFFF, 32'h0, 3'd6, 7'h00, 1'b1);
        @(posedge clk); #1;
        check("reg_rst_q", bus.result_q, 32'd0);
        check("reg_rst_nq", 32'(bus.negative_q), 32'd0);
        drive(32'h0, 32'h0, 3'd0, 7'h00, 1'b1);
        @(posedge clk); #1;
        check("reg_rst_zq", 32'(bus.zero_q), 32'd0);

        // Randomized operations, occasionally asserting reset.
        for (int i = 0; i < 400; i++) begin
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 7) == 0) b = a;
            if ($urandom_range(0, 9) == 0) a = 32'h0;
            f3 = 3'($urandom_range(0, 7));
            f7 = 7'($urandom);
            do_rst = ($urandom_range(0, 9) == 0);
            drive(a, b, f3, f7, do_rst);
            exp_r = ref_alu(a, b, f3, f7);
            check("rnd_res", bus.result, exp_r);
            check("rnd_n", 32'(bus.negative), 32'(exp_r[31]));
            check("rnd_z", 32'(bus.zero), 32'(exp_r == 32'h0));
            r_exp_q = do_rst ? 32'h0 : exp_r;
            n_exp_q = do_rst ? 1'b0 : exp_r[31];
            z_exp_q = do_rst ? 1'b0 : (exp_r == 32'h0);
            @(posedge clk); #1;
            check("rnd_result_q", bus.result_q, r_exp_q);
            check("rnd_negative_q", 32'(bus.negative_q), 32'(n_exp_q));
            check("rnd_zero_q", 32'(bus.zero_q), 32'(z_exp_q));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
